// File: rtl/pipeline_exec_ctrl.sv
// pipeline_exec_ctrl: host RUN/STEP/HALT sequencer gating pipeline advance, with halt-opcode drain and cycle counter
module pipeline_exec_ctrl #(
  parameter int          DRAIN_CYCLES = 4,
  parameter int          CNT_W        = 32,
  parameter logic [5:0]  HALT_OPCODE  = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  output logic             pipe_en,
  output logic             pipe_flush,
  output logic             busy,
  output logic             halted,
  output logic             done_pulse,
  output logic [CNT_W-1:0] cycle_cnt
);
  localparam int DW = DRAIN_CYCLES < 2 ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_DRAIN, S_HALTED} state_t;
  localparam state_t HALT_NEXT = DRAIN_CYCLES == 0 ? S_HALTED : S_DRAIN;
  state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q;
  logic done_q, acc, halt_det, stop;
  assign busy       = state_q inside {S_RUN, S_STEP, S_DRAIN};
  assign pipe_en    = busy;
  assign halted     = state_q == S_HALTED;
  assign cmd_ready  = state_q inside {S_IDLE, S_RUN, S_HALTED};
  assign acc        = cmd_valid && cmd_ready;
  assign halt_det   = id_valid && id_instr[31:26] == HALT_OPCODE && state_q inside {S_RUN, S_STEP};
  assign stop       = halt_det || (state_q == S_RUN && acc && cmd_op == 2'b11);
  assign pipe_flush = halt_det;
  assign done_pulse = done_q;
  assign cycle_cnt  = cnt_q;
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE:   state_d = !acc ? S_IDLE : cmd_op == 2'b01 ? S_RUN : cmd_op == 2'b10 ? S_STEP :
                          cmd_op == 2'b11 ? S_HALTED : S_IDLE;
      S_RUN, S_STEP: begin
        if (stop) begin
          state_d = HALT_NEXT;
          drain_d = DRAIN_INIT;
        end else if (state_q == S_STEP) state_d = S_IDLE;
      end
      S_DRAIN: begin
        drain_d = drain_q - 1'b1;
        state_d = drain_q <= DW'(1) ? S_HALTED : S_DRAIN;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= state_d == S_HALTED && state_q != S_HALTED;
      if (pipe_en && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule
